load_use_hazard_ctrl: RTL and testbench

- Pipeline hazard controller that sits directly upstream of the EX-stage forwarding unit.
- Forwarding from MEM1/MEM2 is suppressed for loads, and load data first becomes forwardable at MEM3. This block therefore holds a consumer in ID until its load producer is far enough ahead for forwarding to cover it.
- It also sequences branch/jump redirect flushes and honours a global memory freeze.
- It drives the PC, IF/ID and ID/EX pipeline-register control.

---
 rtl/load_use_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_load_use_hazard_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/load_use_hazard_ctrl.sv
// Load-use hazard controller: holds the ID instruction until its load producer can be forwarded,
// sequences redirect flushes, honours a global memory freeze and counts inserted load-use bubbles.
module load_use_hazard_ctrl #(
    parameter int unsigned RF_SIZE = 5,
    parameter int unsigned PERF_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               EnRs1_id,
    input  logic               EnRs2_id,
    input  logic               EnMemW_id,
    input  logic [RF_SIZE-1:0] Rs1Idx_id,
    input  logic [RF_SIZE-1:0] Rs2Idx_id,
    input  logic               EnMemR_ex,
    input  logic [RF_SIZE-1:0] RdIdx_ex,
    input  logic               EnMemR_mem1,
    input  logic [RF_SIZE-1:0] RdIdx_mem1,
    input  logic               Redirect_ex,
    input  logic               Freeze,
    output logic               Stall_pc,
    output logic               Stall_ifid,
    output logic               Bubble_idex,
    output logic               Flush_ifid,
    output logic               Flush_idex,
    output logic               Stalling,
    output logic [PERF_W-1:0]  LoadUseStalls
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    logic [0:0] state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic [1:0] need;
    logic       alu_ex, st_ex, alu_m1;
    logic       stall;

    // Bubble requirement: loads forward from MEM3, so an ALU consumer needs the load two stages ahead
    // of EX, while store data is consumed one stage later and tolerates one stage less.
    always_comb begin
        alu_ex = EnMemR_ex && (RdIdx_ex != '0) &&
                 ((EnRs1_id && (Rs1Idx_id == RdIdx_ex)) || (EnRs2_id && (Rs2Idx_id == RdIdx_ex)));
        st_ex  = EnMemR_ex && (RdIdx_ex != '0) &&
                 EnMemW_id && !EnRs2_id && (Rs2Idx_id == RdIdx_ex);
        alu_m1 = EnMemR_mem1 && (RdIdx_mem1 != '0) &&
                 ((EnRs1_id && (Rs1Idx_id == RdIdx_mem1)) || (EnRs2_id && (Rs2Idx_id == RdIdx_mem1)));
        if (alu_ex)
            need = 2'd2;
        else if (st_ex || alu_m1)
            need = 2'd1;
        else
            need = 2'd0;
    end

    // Next state and control outputs; reset and freeze force all pipeline controls low.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stall      = 1'b0;
        Flush_ifid = 1'b0;
        Flush_idex = 1'b0;
        if (!rst_n || Freeze) begin
            state_nxt = state;
        end else if (Redirect_ex) begin
            Flush_ifid = 1'b1;
            Flush_idex = 1'b1;
            state_nxt  = RUN;
            cnt_nxt    = 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (need != 2'd0) begin
                        stall = 1'b1;
                        if (need == 2'd2) begin
                            state_nxt = STALL;
                            cnt_nxt   = need - 2'd1;
                        end
                    end
                end
                default: begin
                    stall = 1'b1;
                    if (cnt <= 2'd1) begin
                        state_nxt = RUN;
                        cnt_nxt   = 2'd0;
                    end else begin
                        cnt_nxt = cnt - 2'd1;
                    end
                end
            endcase
        end
        Stall_pc    = stall;
        Stall_ifid  = stall;
        Bubble_idex = stall;
        Stalling    = rst_n && (state == STALL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Saturating bubble counter; Bubble_idex is already low while frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            LoadUseStalls <= '0;
        else if (Bubble_idex && !Freeze && (LoadUseStalls != '1))
            LoadUseStalls <= LoadUseStalls + PERF_W'(1);
    end

endmodule

// File: tb/tb_load_use_hazard_ctrl.sv
// Randomized and directed bench for load_use_hazard_ctrl against a remaining-bubble reference model.
module tb_load_use_hazard_ctrl;

    localparam int unsigned RF_SIZE = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               EnRs1_id, EnRs2_id, EnMemW_id;
    logic [RF_SIZE-1:0] Rs1Idx_id, Rs2Idx_id;
    logic               EnMemR_ex, EnMemR_mem1;
    logic [RF_SIZE-1:0] RdIdx_ex, RdIdx_mem1;
    logic               Redirect_ex, Freeze;
    logic               Stall_pc, Stall_ifid, Bubble_idex, Flush_ifid, Flush_idex, Stalling;
    logic [15:0]        LoadUseStalls;
    logic               s_Stall_pc, s_Stall_ifid, s_Bubble_idex, s_Flush_ifid, s_Flush_idex, s_Stalling;
    logic [1:0]         s_LoadUseStalls;

    int tests = 0;
    int fails = 0;

    // Reference model: bubbles still owed to the held instruction, and total bubbles issued.
    int m_pend = 0;
    int m_bubbles = 0;

    always #5 clk = ~clk;

    load_use_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .EnRs1_id(EnRs1_id), .EnRs2_id(EnRs2_id), .EnMemW_id(EnMemW_id),
        .Rs1Idx_id(Rs1Idx_id), .Rs2Idx_id(Rs2Idx_id),
        .EnMemR_ex(EnMemR_ex), .RdIdx_ex(RdIdx_ex),
        .EnMemR_mem1(EnMemR_mem1), .RdIdx_mem1(RdIdx_mem1),
        .Redirect_ex(Redirect_ex), .Freeze(Freeze),
        .Stall_pc(Stall_pc), .Stall_ifid(Stall_ifid), .Bubble_idex(Bubble_idex),
        .Flush_ifid(Flush_ifid), .Flush_idex(Flush_idex), .Stalling(Stalling),
        .LoadUseStalls(LoadUseStalls)
    );

    load_use_hazard_ctrl #(.RF_SIZE(RF_SIZE), .PERF_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .EnRs1_id(EnRs1_id), .EnRs2_id(EnRs2_id), .EnMemW_id(EnMemW_id),
        .Rs1Idx_id(Rs1Idx_id), .Rs2Idx_id(Rs2Idx_id),
        .EnMemR_ex(EnMemR_ex), .RdIdx_ex(RdIdx_ex),
        .EnMemR_mem1(EnMemR_mem1), .RdIdx_mem1(RdIdx_mem1),
        .Redirect_ex(Redirect_ex), .Freeze(Freeze),
        .Stall_pc(s_Stall_pc), .Stall_ifid(s_Stall_ifid), .Bubble_idex(s_Bubble_idex),
        .Flush_ifid(s_Flush_ifid), .Flush_idex(s_Flush_idex), .Stalling(s_Stalling),
        .LoadUseStalls(s_LoadUseStalls)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Bubbles owed by a fresh ID instruction: the largest requirement over all producer matches.
    function automatic int need_of(input logic e1, e2, ew, input int r1, r2,
                                   input logic lex, input int rex, input logic lm, input int rm);
        int n = 0;
        bit alu_ex = lex && rex != 0 && ((e1 && r1 == rex) || (e2 && r2 == rex));
        bit st_ex  = lex && rex != 0 && ew && !e2 && r2 == rex;
        bit alu_m1 = lm && rm != 0 && ((e1 && r1 == rm) || (e2 && r2 == rm));
        if (alu_ex) n = 2;
        if (st_ex && n < 1) n = 1;
        if (alu_m1 && n < 1) n = 1;
        return n;
    endfunction

    // One cycle: drive inputs at negedge, check combinational outputs, then advance the model.
    task automatic step(input logic e1, e2, ew, input int r1, r2, input logic lex, input int rex,
                        input logic lm, input int rm, input logic rd, fz, rn);
        bit bub, flush, stl;
        @(negedge clk);
        EnRs1_id = e1; EnRs2_id = e2; EnMemW_id = ew;
        Rs1Idx_id = RF_SIZE'(r1); Rs2Idx_id = RF_SIZE'(r2);
        EnMemR_ex = lex; RdIdx_ex = RF_SIZE'(rex);
        EnMemR_mem1 = lm; RdIdx_mem1 = RF_SIZE'(rm);
        Redirect_ex = rd; Freeze = fz; rst_n = rn;
        #1;
        if (!rn) begin
            m_pend = 0;
            m_bubbles = 0;
        end
        bub = 0; flush = 0;
        stl = rn && m_pend > 0;
        if (rn && !fz) begin
            if (rd) begin
                flush = 1;
                m_pend = 0;
            end else if (m_pend > 0) begin
                bub = 1;
                m_pend--;
            end else begin
                m_pend = need_of(e1, e2, ew, r1, r2, lex, rex, lm, rm);
                if (m_pend > 0) begin
                    bub = 1;
                    m_pend--;
                end
            end
        end
        check("stall_pc", 32'(Stall_pc), 32'(bub));
        check("stall_ifid", 32'(Stall_ifid), 32'(bub));
        check("bubble_idex", 32'(Bubble_idex), 32'(bub));
        check("flush_ifid", 32'(Flush_ifid), 32'(flush));
        check("flush_idex", 32'(Flush_idex), 32'(flush));
        check("stalling", 32'(Stalling), 32'(stl));
        check("load_use_stalls", 32'(LoadUseStalls), 32'(m_bubbles > 65535 ? 65535 : m_bubbles));
        check("small_bubble", 32'(s_Bubble_idex), 32'(bub));
        check("small_stalls_sat", 32'(s_LoadUseStalls), 32'(m_bubbles > 3 ? 3 : m_bubbles));
        m_bubbles += int'(bub);
    endtask

    task automatic idle(input logic rn);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rn);
    endtask

    initial begin
        rst_n = 1'b0;
        EnRs1_id = 0; EnRs2_id = 0; EnMemW_id = 0; Rs1Idx_id = '0; Rs2Idx_id = '0;
        EnMemR_ex = 0; RdIdx_ex = '0; EnMemR_mem1 = 0; RdIdx_mem1 = '0;
        Redirect_ex = 0; Freeze = 0;
        // Reset held with a live hazard on the inputs: everything must stay low.
        step(1, 0, 0, 5, 0, 1, 5, 0, 0, 0, 0, 0);
        idle(1);

        // ALU use of an EX load: two bubbles, Stalling in the second.
        step(1, 0, 0, 5, 0, 1, 5, 0, 0, 0, 0, 1);
        step(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        check("two_bubble_count", 32'(LoadUseStalls), 32'd2);

        // Store data vs EX load: one bubble; vs MEM1 load: none.
        step(0, 0, 1, 0, 7, 1, 7, 0, 0, 0, 0, 1);
        idle(1);
        step(0, 0, 1, 0, 7, 0, 0, 1, 7, 0, 0, 1);
        // x0 never hazards; rs2 vs MEM1 load is one bubble.
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 3, 0, 0, 1, 3, 0, 0, 1);
        idle(1);

        // Redirect in the second cycle of a two-bubble stall.
        step(1, 0, 0, 5, 0, 1, 5, 0, 0, 0, 0, 1);
        step(1, 0, 0, 5, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(1);

        // Freeze for three cycles mid-stall, then the remaining bubble.
        step(1, 0, 0, 5, 0, 1, 5, 0, 0, 0, 0, 1);
        repeat (3) step(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // Asynchronous reset mid-stall.
        step(1, 0, 0, 5, 0, 1, 5, 0, 0, 0, 0, 1);
        step(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        check("count_after_reset", 32'(LoadUseStalls), 32'd0);

        // Five single bubbles saturate the 2-bit counter.
        repeat (5) begin
            step(1, 0, 0, 4, 0, 0, 0, 1, 4, 0, 0, 1);
        end
        idle(1);

        // Randomized traffic over a small register set to provoke frequent matches.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 49) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
